// File: rtl/core_pkg.sv
// Shared core types and constants used by the fetch stage.
package core_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, instr}; push and pop may coincide at any fill level.
module fetch_fifo
   import core_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 2 * XLEN
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  logic [WIDTH-1:0]       wdata_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == DEPTH_C);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_pop  = pop_i && !empty_o;
   // when full, a same-cycle pop frees the slot the push lands in
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited imem requests, prefetch buffer, redirect flush.
// Optional perf counters enabled with FETCH_PERF_CNT_EN.
//
// state | meaning
// IDLE  | one cycle after reset, no requests
// RUN   | issuing requests, responses pushed to the buffer
// DRAIN | after redirect, dropping stale responses until none outstanding
module fetch_unit
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid_o,
   input  logic            imem_req_ready_i,
   output logic [XLEN-1:0] imem_req_addr_o,
   input  logic            imem_rsp_valid_i,
   input  logic [XLEN-1:0] imem_rsp_data_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            instr_valid_o,
   input  logic            instr_ready_i,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_incr_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     perf_fetched_o,
   output logic [31:0]     perf_stall_o,
   output logic [31:0]     perf_flush_o
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] CREDIT = (CW+1)'(FIFO_DEPTH);

   fetch_state_t      state_q, state_d;
   logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]     outst_q, outst_d;
   logic [CW-1:0]     fifo_count;
   logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [2*XLEN-1:0] fifo_rdata;
   logic              req_fire, rsp_take;
   logic [XLEN-1:0]   redirect_pc;

   assign imem_req_valid_o = (state_q == RUN) && (({1'b0, fifo_count} + {1'b0, outst_q}) < CREDIT);
   assign imem_req_addr_o  = fetch_pc_q;
   assign req_fire         = imem_req_valid_o && imem_req_ready_i;
   // responses with nothing outstanding belong to a pre-reset request
   assign rsp_take         = imem_rsp_valid_i && (outst_q != '0);
   assign redirect_pc      = {redirect_pc_i[XLEN-1:2], 2'b00};

   assign fifo_push = rsp_take && (state_q == RUN) && !redirect_i && (!fifo_full || fifo_pop);
   assign fifo_pop  = instr_valid_o && instr_ready_i && !redirect_i;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (2 * XLEN)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .flush_i (redirect_i),
      .wdata_i ({rsp_pc_q, imem_rsp_data_i}),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign instr_valid_o = !fifo_empty;
   assign instr_o       = instr_valid_o ? fifo_rdata[XLEN-1:0] : INSTR_NOP;
   assign pc_o          = instr_valid_o ? fifo_rdata[2*XLEN-1:XLEN] : '0;
   assign pc_incr_o     = pc_o + 32'd4;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      outst_d    = outst_q;
      if (req_fire) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
         outst_d    = outst_d + CW'(1);
      end
      if (rsp_take) begin
         outst_d = outst_d - CW'(1);
         if (fifo_push) rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (redirect_i) begin
         fetch_pc_d = redirect_pc;
         rsp_pc_d   = redirect_pc;
      end
      case (state_q)
         IDLE:    state_d = RUN;
         RUN:     if (redirect_i && (outst_d != '0)) state_d = DRAIN;
         DRAIN:   if (outst_d == '0) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         outst_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         outst_q    <= outst_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_q, perf_stall_q, perf_flush_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched_q <= '0;
         perf_stall_q   <= '0;
         perf_flush_q   <= '0;
      end else begin
         if (fifo_pop)                              perf_fetched_q <= perf_fetched_q + 32'd1;
         if ((state_q == RUN) && !instr_valid_o)    perf_stall_q   <= perf_stall_q + 32'd1;
         if (redirect_i)                            perf_flush_q   <= perf_flush_q + 32'd1;
      end
   end

   assign perf_fetched_o = perf_fetched_q;
   assign perf_stall_o   = perf_stall_q;
   assign perf_flush_o   = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a reference model of the fetch queue plus a second instance for PC wrap.
module tb_fetch_unit;

   localparam int          DEPTH  = 2;
   localparam logic [31:0] RESET2 = 32'hFFFF_FFF8;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   typedef struct {
      int          due;
      logic [31:0] addr;
   } ent_t;

   logic clk, rst;
   logic imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic [31:0] imem_req_addr, imem_rsp_data;
   logic redirect, instr_valid, instr_ready;
   logic [31:0] redirect_pc, instr, pc, pc_incr;

   logic req2_valid, rsp2_valid, instr2_valid;
   logic [31:0] req2_addr, rsp2_data, instr2, pc2, pc2_incr;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_stall, perf_flush;
   logic [31:0] perf2_fetched, perf2_stall, perf2_flush;
`endif

   fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) u_dut (
      .clk              (clk),
      .rst              (rst),
      .imem_req_valid_o (imem_req_valid),
      .imem_req_ready_i (imem_req_ready),
      .imem_req_addr_o  (imem_req_addr),
      .imem_rsp_valid_i (imem_rsp_valid),
      .imem_rsp_data_i  (imem_rsp_data),
      .redirect_i       (redirect),
      .redirect_pc_i    (redirect_pc),
      .instr_valid_o    (instr_valid),
      .instr_ready_i    (instr_ready),
      .instr_o          (instr),
      .pc_o             (pc),
      .pc_incr_o        (pc_incr)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched_o   (perf_fetched),
      .perf_stall_o     (perf_stall),
      .perf_flush_o     (perf_flush)
`endif
   );

   fetch_unit #(.RESET_PC(RESET2), .FIFO_DEPTH(DEPTH)) u_wrap (
      .clk              (clk),
      .rst              (rst),
      .imem_req_valid_o (req2_valid),
      .imem_req_ready_i (1'b1),
      .imem_req_addr_o  (req2_addr),
      .imem_rsp_valid_i (rsp2_valid),
      .imem_rsp_data_i  (rsp2_data),
      .redirect_i       (1'b0),
      .redirect_pc_i    (32'h0),
      .instr_valid_o    (instr2_valid),
      .instr_ready_i    (1'b1),
      .instr_o          (instr2),
      .pc_o             (pc2),
      .pc_incr_o        (pc2_incr)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched_o   (perf2_fetched),
      .perf_stall_o     (perf2_stall),
      .perf_flush_o     (perf2_flush)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   int lat    = 1;
   ent_t pq[$];
   ent_t pq2[$];
   logic [31:0] fifo_m[$];
   bit run_m, drain_m;
   logic [31:0] next_addr, exp2;
   logic [31:0] hs_m, stall_m, flush_m;
   int issued_m = 0;
   int n2 = 0;
   logic [31:0] seen2 [3];

   function automatic logic [31:0] mk(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one clock: called at a negedge with inputs set; checks, updates the model, returns at next negedge
   task automatic cycle();
      bit rsp_now, rsp2_now, mv, fire, pop;
      ent_t e;
      if (rst) begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
         rsp2_valid     = 1'b0;
         rsp2_data      = '0;
         pq.delete();
         pq2.delete();
         fifo_m.delete();
         run_m = 0;
         drain_m = 0;
         next_addr = 32'h0;
         exp2 = RESET2;
         hs_m = 0;
         stall_m = 0;
         flush_m = 0;
         @(posedge clk);
         cyc++;
         @(negedge clk);
         return;
      end
      rsp_now = (pq.size() > 0) && (pq[0].due == cyc + 1);
      imem_rsp_valid = rsp_now;
      imem_rsp_data  = rsp_now ? mk(pq[0].addr) : 32'h0;
      mv = run_m && !drain_m && ((fifo_m.size() + pq.size()) < DEPTH);
      chk("req_valid", imem_req_valid, mv);
      if (mv) chk("req_addr", imem_req_addr, next_addr);
      chk("instr_valid", instr_valid, fifo_m.size() > 0);
      if (fifo_m.size() > 0) begin
         chk("pc", pc, fifo_m[0]);
         chk("instr", instr, mk(fifo_m[0]));
         chk("pc_incr", pc_incr, fifo_m[0] + 32'd4);
      end else begin
         chk("instr_nop", instr, NOP);
         chk("pc_idle", pc, 32'h0);
      end
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, hs_m);
      chk("perf_stall", perf_stall, stall_m);
      chk("perf_flush", perf_flush, flush_m);
`endif
      rsp2_now   = (pq2.size() > 0) && (pq2[0].due == cyc + 1);
      rsp2_valid = rsp2_now;
      rsp2_data  = rsp2_now ? mk(pq2[0].addr) : 32'h0;
      if (rsp2_now) void'(pq2.pop_front());
      if (instr2_valid) begin
         if (n2 < 3) seen2[n2] = pc2;
         n2++;
         chk("wrap_pc", pc2, exp2);
         chk("wrap_instr", instr2, mk(exp2));
         exp2 = exp2 + 32'd4;
      end
      if (req2_valid) begin
         e.due = cyc + 2;
         e.addr = req2_addr;
         pq2.push_back(e);
      end
      fire = mv && imem_req_ready;
      pop  = (fifo_m.size() > 0) && instr_ready && !redirect;
      if (run_m && !drain_m && fifo_m.size() == 0) stall_m++;
      if (pop) begin
         void'(fifo_m.pop_front());
         hs_m++;
      end
      if (rsp_now) begin
         e = pq.pop_front();
         if (run_m && !drain_m && !redirect) fifo_m.push_back(e.addr);
      end
      if (fire) begin
         e.due = cyc + 1 + lat;
         e.addr = next_addr;
         pq.push_back(e);
         next_addr = next_addr + 32'd4;
         issued_m++;
      end
      if (redirect) begin
         fifo_m.delete();
         next_addr = {redirect_pc[31:2], 2'b00};
         flush_m++;
         drain_m = (pq.size() > 0);
      end else if (drain_m && pq.size() == 0) begin
         drain_m = 0;
      end
      run_m = 1;
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic chk_reset_values();
      chk("rst_req_valid", imem_req_valid, 1'b0);
      chk("rst_req_addr", imem_req_addr, 32'h0);
      chk("rst_instr_valid", instr_valid, 1'b0);
      chk("rst_instr", instr, NOP);
      chk("rst_pc", pc, 32'h0);
      chk("rst_pc_incr", pc_incr, 32'h4);
      chk("rst_wrap_addr", req2_addr, RESET2);
`ifdef FETCH_PERF_CNT_EN
      chk("rst_perf_fetched", perf_fetched, 32'h0);
      chk("rst_perf_stall", perf_stall, 32'h0);
      chk("rst_perf_flush", perf_flush, 32'h0);
`endif
   endtask

   initial begin
      int n;
      int issued0;
      logic [31:0] fl0, fe0;
      rst = 1'b1;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = '0;
      redirect = 1'b0;
      redirect_pc = '0;
      instr_ready = 1'b1;
      rsp2_valid = 1'b0;
      rsp2_data = '0;
      fl0 = '0;
      fe0 = '0;
      for (int i = 0; i < 3; i++) seen2[i] = 32'hDEAD_BEEF;
      @(negedge clk);
      repeat (3) cycle();
      chk_reset_values();

      // IDLE cycle then first request
      rst = 1'b0;
      cycle();
      chk("first_req_valid", imem_req_valid, 1'b1);
      chk("first_req_addr", imem_req_addr, 32'h0);

      n = 0;
      while (hs_m < 8 && n < 60) begin cycle(); n++; end
      chk("stream_timeout", n < 60, 1'b1);

      // decode stall: credit stops requests once buffer plus in-flight fills
      instr_ready = 1'b0;
      issued0 = issued_m;
      repeat (10) cycle();
      chk("stall_req_count_le_depth", (issued_m - issued0) <= DEPTH, 1'b1);
      chk("stall_req_valid_low", imem_req_valid, 1'b0);
      chk("stall_instr_valid", instr_valid, 1'b1);
      instr_ready = 1'b1;

      imem_req_ready = 1'b0;
      repeat (5) cycle();
      chk("hold_req_valid", imem_req_valid, 1'b1);
      chk("hold_req_addr", imem_req_addr, next_addr);
      imem_req_ready = 1'b1;

      // redirect with two requests in flight and 3-cycle memory
      lat = 3;
      n = 0;
      while (pq.size() != 2 && n < 30) begin cycle(); n++; end
      chk("two_outstanding_timeout", n < 30, 1'b1);
      redirect = 1'b1;
      redirect_pc = 32'h0000_0100;
      cycle();
      redirect = 1'b0;
      chk("drain_instr_valid", instr_valid, 1'b0);
      chk("drain_req_valid", imem_req_valid, 1'b0);
      n = 0;
      while (!instr_valid && n < 30) begin cycle(); n++; end
      chk("redir100_timeout", n < 30, 1'b1);
      chk("redir100_first_pc", pc, 32'h0000_0100);
      chk("redir100_first_instr", instr, 32'h5A5A_0100);

      // unaligned target
      lat = 1;
      repeat (3) cycle();
      redirect = 1'b1;
      redirect_pc = 32'h0000_0203;
      cycle();
      redirect = 1'b0;
      n = 0;
      while (!instr_valid && n < 30) begin cycle(); n++; end
      chk("redir203_timeout", n < 30, 1'b1);
      chk("redir203_first_pc", pc, 32'h0000_0200);

      // redirect coinciding with a response and a pop
      n = 0;
      while (!(instr_valid && pq.size() > 0 && pq[0].due == cyc + 1) && n < 40) begin cycle(); n++; end
      chk("coincide_timeout", n < 40, 1'b1);
`ifdef FETCH_PERF_CNT_EN
      fl0 = perf_flush;
      fe0 = perf_fetched;
`endif
      redirect = 1'b1;
      redirect_pc = 32'h0000_0300;
      cycle();
      redirect = 1'b0;
      chk("coincide_fifo_empty", instr_valid, 1'b0);
`ifdef FETCH_PERF_CNT_EN
      chk("coincide_perf_flush", perf_flush, fl0 + 32'd1);
      chk("coincide_perf_fetched", perf_fetched, fe0);
`endif
      n = 0;
      while (!instr_valid && n < 30) begin cycle(); n++; end
      chk("redir300_first_pc", pc, 32'h0000_0300);

      // reset mid-operation
      rst = 1'b1;
      cycle();
      chk_reset_values();
      rst = 1'b0;
      n = 0;
      while (hs_m < 4 && n < 40) begin cycle(); n++; end
      chk("post_reset_stream_timeout", n < 40, 1'b1);

      chk("wrap_seen0", seen2[0], 32'hFFFF_FFF8);
      chk("wrap_seen1", seen2[1], 32'hFFFF_FFFC);
      chk("wrap_seen2", seen2[2], 32'h0000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
